// File: rtl/multi_digit_seg_driver.sv
// multi_digit_seg_driver: time-multiplexed hex 7-segment scanner with anti-ghost blanking,
// leading-zero suppression and selectable common-anode/common-cathode polarity.
module multi_digit_seg_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter bit COMMON_ANODE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [6:0] LUT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                       7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] sh_dig;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic                    sh_lz;
   logic                    pend;
   logic [NUM_DIGITS-1:0]   sup;
   logic                    z;
   logic [3:0]              nib;
   logic                    on;
   logic                    slot_end;
   logic                    idx_end;
   // A digit is suppressed when it and every digit to its left are zero.
   always_comb begin
      z = 1'b1;
      sup = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         z = z & (sh_dig[4*i +: 4] == 4'd0);
         sup[i] = sh_lz & z & (i != 0);
      end
   end
   assign nib      = sh_dig[4*idx +: 4];
   assign on       = enable && (32'(cnt) >= BLANK_CYCLES);
   assign slot_end = cnt == CW'(REFRESH_DIV - 1);
   assign idx_end  = idx == IW'(NUM_DIGITS - 1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         sh_dig     <= '0;
         sh_dp      <= '0;
         sh_lz      <= 1'b0;
         pend       <= 1'b0;
         frame_tick <= 1'b0;
         seg        <= {7{COMMON_ANODE}};
         dp         <= COMMON_ANODE;
         an         <= {NUM_DIGITS{COMMON_ANODE}};
      end else begin
         if (load) begin
            sh_dig <= digits_in;
            sh_dp  <= dp_in;
            sh_lz  <= lz_en;
         end
         cnt        <= enable && !slot_end ? cnt + 1'b1 : '0;
         idx        <= !enable ? '0 : slot_end ? (idx_end ? '0 : idx + 1'b1) : idx;
         pend       <= enable & slot_end & idx_end;
         frame_tick <= pend & enable;
         seg        <= {7{COMMON_ANODE}} ^ (on && !sup[idx] ? LUT[nib] : 7'h00);
         dp         <= COMMON_ANODE ^ (on && sh_dp[idx]);
         an         <= {NUM_DIGITS{COMMON_ANODE}} ^ (on ? NUM_DIGITS'(1) << idx : '0);
      end
   end
endmodule

// File: tb/tb_multi_digit_seg_driver.sv
// tb_multi_digit_seg_driver: checks common-anode and common-cathode instances against a
// slot-position model of the scan (position p counts enabled cycles since restart).
module tb_multi_digit_seg_driver;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0;
   logic        lz_en = 1'b0;
   logic [6:0]  a_seg, c_seg;
   logic        a_dp, c_dp, a_ft, c_ft;
   logic [3:0]  a_an, c_an;
   int          errors = 0;
   int          checks = 0;
   int          p = 0;
   logic [15:0] m_dig = '0;
   logic [3:0]  m_dp = '0;
   logic        m_lz = 1'b0;
   logic [12:0] exp_a, exp_c;
   logic [6:0]  lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   always #5 clk = ~clk;

   multi_digit_seg_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .COMMON_ANODE(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
      .dp_in(dp_in), .lz_en(lz_en), .seg(a_seg), .dp(a_dp), .an(a_an), .frame_tick(a_ft));

   multi_digit_seg_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .COMMON_ANODE(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
      .dp_in(dp_in), .lz_en(lz_en), .seg(c_seg), .dp(c_dp), .an(c_an), .frame_tick(c_ft));

   // Predict the outputs of the coming edge, advance one clock, then update the model.
   task automatic tick();
      int d, ph;
      logic on, sp, ft, dpv;
      logic [6:0] s;
      logic [3:0] a;
      d   = (p / 4) % 4;
      ph  = p % 4;
      on  = rst_n && enable && ph >= 1;
      sp  = m_lz && d != 0 && (m_dig >> (4 * d)) == 16'd0;
      s   = on && !sp ? lut[m_dig[4*d +: 4]] : 7'h00;
      a   = on ? 4'b0001 << d : 4'h0;
      dpv = on && m_dp[d];
      ft  = rst_n && enable && p > 0 && p % 16 == 0;
      exp_c = {s, dpv, a, ft};
      exp_a = {~s, ~dpv, ~a, ft};
      @(posedge clk);
      #1;
      if (!rst_n) begin
         p = 0;
         m_dig = '0;
         m_dp = '0;
         m_lz = 1'b0;
      end else begin
         p = enable ? p + 1 : 0;
         if (load) begin
            m_dig = digits_in;
            m_dp = dp_in;
            m_lz = lz_en;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b1;
      load = 1'b1;
      digits_in = 16'($urandom);
      dp_in = 4'($urandom);
      lz_en = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({a_seg, a_dp, a_an, a_ft} !== 13'h1FFE) begin
            errors++;
            $display("FAIL reset_hold: got %h required %h", {a_seg, a_dp, a_an, a_ft}, 13'h1FFE);
         end
      end
      load = 1'b0;
      rst_n = 1'b1;
      tick();
      checks++;
      if (a_an !== 4'hF || a_seg !== 7'h7F) begin
         errors++;
         $display("FAIL reset_blank: an=%h seg=%h required an=F seg=7F", a_an, a_seg);
      end
      tick();
      checks++;
      if (a_an !== 4'hE || a_seg !== 7'h01) begin
         errors++;
         $display("FAIL reset_first_digit: an=%h seg=%h required an=E seg=01", a_an, a_seg);
      end
   endtask

   task automatic test_scan();
      int fts = 0;
      load = 1'b1;
      digits_in = 16'h1234;
      dp_in = 4'b0010;
      lz_en = 1'b0;
      tick();
      load = 1'b0;
      for (int i = 0; i < 48; i++) begin
         tick();
         checks++;
         if ({a_seg, a_dp, a_an, a_ft, c_seg, c_dp, c_an, c_ft} !== {exp_a, exp_c}) begin
            errors++;
            $display("FAIL scan cyc %0d: got %h/%h required %h/%h", i,
                     {a_seg, a_dp, a_an, a_ft}, {c_seg, c_dp, c_an, c_ft}, exp_a, exp_c);
         end
         if (a_an == 4'hD) begin
            checks++;
            if (a_seg !== 7'h06 || a_dp !== 1'b0) begin
               errors++;
               $display("FAIL scan_digit1: seg=%h dp=%b required seg=06 dp=0", a_seg, a_dp);
            end
         end
         fts += int'(a_ft);
      end
      checks++;
      if (fts != 3) begin
         errors++;
         $display("FAIL frame_tick_count: got %0d required 3", fts);
      end
   endtask

   task automatic test_leading_zero();
      load = 1'b1;
      digits_in = 16'h0050;
      dp_in = 4'b0000;
      lz_en = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if ({a_seg, a_dp, a_an, a_ft, c_seg, c_dp, c_an, c_ft} !== {exp_a, exp_c}) begin
            errors++;
            $display("FAIL lz_0050 cyc %0d: got %h/%h required %h/%h", i,
                     {a_seg, a_dp, a_an, a_ft}, {c_seg, c_dp, c_an, c_ft}, exp_a, exp_c);
         end
         if (a_an == 4'h7 || a_an == 4'hB || a_an == 4'hD || a_an == 4'hE) begin
            checks++;
            if (a_seg !== (a_an == 4'hD ? 7'h24 : a_an == 4'hE ? 7'h01 : 7'h7F)) begin
               errors++;
               $display("FAIL lz_0050_digit an=%h: seg=%h", a_an, a_seg);
            end
         end
      end
      load = 1'b1;
      digits_in = 16'h0000;
      tick();
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if ({a_seg, a_dp, a_an, a_ft, c_seg, c_dp, c_an, c_ft} !== {exp_a, exp_c}) begin
            errors++;
            $display("FAIL lz_0000 cyc %0d: got %h/%h required %h/%h", i,
                     {a_seg, a_dp, a_an, a_ft}, {c_seg, c_dp, c_an, c_ft}, exp_a, exp_c);
         end
         checks++;
         if (a_seg !== (a_an == 4'hE ? 7'h01 : 7'h7F)) begin
            errors++;
            $display("FAIL lz_0000_digit an=%h: seg=%h", a_an, a_seg);
         end
      end
   endtask

   task automatic test_enable_drop();
      int n = 0;
      while (!((p / 4) % 4 == 2 && p % 4 == 2) && n < 32) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 32) begin
         errors++;
         $display("FAIL enable_drop_align: timed out after %0d cycles", n);
      end
      enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({a_seg, a_dp, a_an, a_ft, c_seg, c_dp, c_an, c_ft} !== {13'h1FFE, 13'h0000}) begin
            errors++;
            $display("FAIL enable_off cyc %0d: got %h/%h required 1ffe/0000", i,
                     {a_seg, a_dp, a_an, a_ft}, {c_seg, c_dp, c_an, c_ft});
         end
      end
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({a_seg, a_dp, a_an, a_ft, c_seg, c_dp, c_an, c_ft} !== {exp_a, exp_c}) begin
            errors++;
            $display("FAIL enable_restart cyc %0d: got %h/%h required %h/%h", i,
                     {a_seg, a_dp, a_an, a_ft}, {c_seg, c_dp, c_an, c_ft}, exp_a, exp_c);
         end
         if (i < 2) begin
            checks++;
            if (a_an !== (i == 0 ? 4'hF : 4'hE)) begin
               errors++;
               $display("FAIL enable_restart_an cyc %0d: an=%h", i, a_an);
            end
         end
      end
   endtask

   task automatic test_load_wrap();
      int n = 0;
      while (p % 4 != 3 && n < 8) begin
         tick();
         n++;
      end
      load = 1'b1;
      digits_in = 16'hFFFF;
      dp_in = 4'b0000;
      lz_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         load = 1'b0;
         checks++;
         if ({a_seg, a_dp, a_an, a_ft, c_seg, c_dp, c_an, c_ft} !== {exp_a, exp_c}) begin
            errors++;
            $display("FAIL load_wrap cyc %0d: got %h/%h required %h/%h", i,
                     {a_seg, a_dp, a_an, a_ft}, {c_seg, c_dp, c_an, c_ft}, exp_a, exp_c);
         end
      end
      checks++;
      if (a_seg !== 7'h38 || a_an === 4'hF) begin
         errors++;
         $display("FAIL load_wrap_first_lit: seg=%h an=%h required seg=38 lit", a_seg, a_an);
      end
   endtask

   task automatic test_polarity();
      load = 1'b1;
      digits_in = 16'h8888;
      dp_in = 4'b0000;
      lz_en = 1'b0;
      tick();
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if ({c_seg, c_dp, c_an, c_ft} !== exp_c) begin
            errors++;
            $display("FAIL polarity cyc %0d: got %h required %h", i, {c_seg, c_dp, c_an, c_ft}, exp_c);
         end
         checks++;
         if (c_an == 4'h0 ? c_seg !== 7'h00 : (c_seg !== 7'h7F || !$onehot(c_an))) begin
            errors++;
            $display("FAIL polarity_cc: seg=%h an=%h", c_seg, c_an);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom % 150) != 0;
         enable = ($urandom % 25) != 0;
         load = ($urandom % 6) == 0;
         digits_in = ($urandom % 3) == 0 ? 16'($urandom % 256) : 16'($urandom);
         dp_in = 4'($urandom);
         lz_en = 1'($urandom);
         tick();
         checks++;
         if ({a_seg, a_dp, a_an, a_ft, c_seg, c_dp, c_an, c_ft} !== {exp_a, exp_c}) begin
            errors++;
            $display("FAIL random cyc %0d: got %h/%h required %h/%h", i,
                     {a_seg, a_dp, a_an, a_ft}, {c_seg, c_dp, c_an, c_ft}, exp_a, exp_c);
         end
      end
      rst_n = 1'b1;
      enable = 1'b1;
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_leading_zero();
      test_enable_drop();
      test_load_wrap();
      test_polarity();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
